lsu_riscv: RTL and testbench



---
 rtl/lsu_riscv_pkg.sv | 47 ++++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_riscv.sv | 152 +++++++++++++++
 tb/tb_lsu_riscv.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_riscv_pkg.sv
// lsu_riscv_pkg
//   Shared types and helpers for the load/store unit.
//   - lsu_state_t : IDLE (no access outstanding) / WAIT (one access outstanding)
//   - LDST_*      : access size codes used by the decoder (lsu_size_i)
//   - is_legal()  : size/direction legality (ignores alignment)
//   - be_calc()   : byte enables for a size and byte offset
//   - wdata_rep() : store data replicated across the byte lanes
package lsu_riscv_pkg;

  typedef enum logic {IDLE, WAIT} lsu_state_t;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // Unsigned sizes only make sense for loads, so a store with BU/HU is illegal.
  function automatic logic is_legal(input logic [2:0] size, input logic we);
    case (size)
      LDST_B, LDST_H, LDST_W: return 1'b1;
      LDST_BU, LDST_HU:       return ~we;
      default:                return 1'b0;
    endcase
  endfunction

  // A half always uses an aligned lane pair, so only offset bit 1 picks the pair.
  function automatic logic [3:0] be_calc(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 4'b0001 << off;
      LDST_H, LDST_HU: return 4'b0011 << {off[1], 1'b0};
      LDST_W:          return 4'b1111;
      default:         return 4'b0000;
    endcase
  endfunction

  // Replicating the data lets memory pick whichever lane the enables select.
  function automatic logic [31:0] wdata_rep(input logic [2:0] size, input logic [31:0] data);
    case (size)
      LDST_B, LDST_BU: return {4{data[7:0]}};
      LDST_H, LDST_HU: return {2{data[15:0]}};
      LDST_W:          return data;
      default:         return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
//   Combinational load steering: picks the addressed byte/half out of the
//   memory word and sign- or zero-extends it to 32 bits.
//   Ports:
//     rdata     in  32  word returned by data memory
//     offset    in  2   byte offset of the access (address bits [1:0])
//     size      in  3   LDST_* size code
//     load_data out 32  extended load value
module lsu_load_align
  import lsu_riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection follows the same offset rules as the byte enables, then
  // the size code decides between sign and zero extension.
  always_comb begin
    byte_sel = 8'(rdata >> {offset, 3'b000});
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LDST_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: load_data = {24'h0, byte_sel};
      LDST_H:  load_data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: load_data = {16'h0, half_sel};
      LDST_W:  load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_riscv.sv
// lsu_riscv
//   Load/store unit between the execute stage and the data memory. Turns one
//   core access into a single byte-enabled word request, stalls the core until
//   memory answers (or a timeout expires) and returns extended load data.
//   Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned halves
//   and words with an error pulse instead of issuing them.
//   Ports:
//     clk_i, rst_n_i    clock, asynchronous active-low reset
//     lsu_req_i         core access request (held while stalled)
//     lsu_we_i          1 = store, 0 = load
//     lsu_size_i        LDST_* size code
//     lsu_addr_i        byte address
//     lsu_data_i        store data
//     lsu_stall_req_o   hold the core pipeline
//     lsu_data_o        extended load data, valid in the completion cycle
//     lsu_err_o         one-cycle error pulse (illegal, timeout, misaligned)
//     data_req_o        memory request pulse
//     data_we_o         memory write
//     data_be_o         byte enables
//     data_addr_o       word-aligned address
//     data_wdata_o      lane-replicated store data
//     data_rdata_i      memory read word
//     data_rvalid_i     read data / write acknowledge
module lsu_riscv
  import lsu_riscv_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       acc_size;
  logic [1:0]       acc_off;
  logic             acc_we;

  logic        access_ok;
  logic        idle_req;
  logic        issue;
  logic        reject;
  logic        in_wait;
  logic        done;
  logic        timeout;
  logic [31:0] load_data;

  // Decide whether the access presented in IDLE may go to memory.
  always_comb begin
    access_ok = is_legal(lsu_size_i, lsu_we_i);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((lsu_size_i == LDST_H || lsu_size_i == LDST_HU) && lsu_addr_i[0])
      access_ok = 1'b0;
    if (lsu_size_i == LDST_W && lsu_addr_i[1:0] != 2'b00)
      access_ok = 1'b0;
`endif
  end

  // Event decode. Everything is gated by rst_n_i so every output reads 0
  // while reset is held, even if the core keeps lsu_req_i high. A response
  // arriving in the last allowed WAIT cycle still completes the access.
  always_comb begin
    idle_req = rst_n_i && (state == IDLE) && lsu_req_i;
    issue    = idle_req && access_ok;
    reject   = idle_req && !access_ok;
    in_wait  = rst_n_i && (state == WAIT);
    done     = in_wait && data_rvalid_i;
    timeout  = in_wait && !data_rvalid_i && (wait_cnt == CNT_W'(MAX_WAIT - 1));
  end

  // Load data steering uses the size/offset captured at issue time, since the
  // core may change its address bus while waiting.
  lsu_load_align u_load_align (
    .rdata     (data_rdata_i),
    .offset    (acc_off),
    .size      (acc_size),
    .load_data (load_data)
  );

  // Memory-side outputs only carry values in the issue cycle so the bus is
  // quiet whenever no request is presented.
  always_comb begin
    data_req_o   = issue;
    data_we_o    = issue && lsu_we_i;
    data_be_o    = issue ? be_calc(lsu_size_i, lsu_addr_i[1:0]) : 4'b0000;
    data_addr_o  = issue ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
    data_wdata_o = (issue && lsu_we_i) ? wdata_rep(lsu_size_i, lsu_data_i) : 32'h0;
  end

  // Core-side outputs: stall from issue until the response (or timeout),
  // error on a rejected access or a timeout, load data only on completion.
  always_comb begin
    lsu_stall_req_o = issue || (in_wait && !data_rvalid_i && !timeout);
    lsu_err_o       = reject || timeout;
    lsu_data_o      = (done && !acc_we) ? load_data : 32'h0;
  end

  // Access FSM. A request seen in WAIT is the one already outstanding, so
  // only IDLE looks at lsu_req_i. Reset returns to IDLE, which also makes any
  // late response for an aborted access harmless.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      acc_size <= 3'd0;
      acc_off  <= 2'd0;
      acc_we   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (issue) begin
            state    <= WAIT;
            acc_size <= lsu_size_i;
            acc_off  <= lsu_addr_i[1:0];
            acc_we   <= lsu_we_i;
          end
        end
        WAIT: begin
          if (data_rvalid_i || timeout) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// tb_lsu_riscv
//   Self-checking bench for lsu_riscv: directed cases for the documented
//   scenarios followed by random accesses, all compared against a reference
//   model built from the access rules (lane arithmetic, legality sets).
//   Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_riscv;

  localparam int MAX_WAIT = 255;

  logic        clk_i;
  logic        rst_n_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_stall_req_o;
  logic [31:0] lsu_data_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  lsu_riscv #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_data_o      (lsu_data_o),
    .lsu_err_o       (lsu_err_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_rdata_i    (data_rdata_i),
    .data_rvalid_i   (data_rvalid_i)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: legality from the size/direction sets (plus alignment
  // when the trap is enabled).
  function automatic bit model_legal(input bit we, input int size, input int o);
    bit ok;
    ok = (size inside {0, 1, 2}) || (!we && (size inside {4, 5}));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 1 || size == 5) && (o % 2) != 0) ok = 1'b0;
    if (size == 2 && o != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Reference model: enables as plain shifts of a lane mask.
  function automatic logic [31:0] model_be(input int size, input int o);
    if (size == 0 || size == 4) return 32'(1 << o);
    if (size == 1 || size == 5) return 32'(3 << (o & 2));
    return 32'd15;
  endfunction

  // Reference model: replication as multiplication by a lane pattern.
  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
    if (size == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Reference model: extract by shifting the lane down, extend by subtracting
  // the field range when the sign bit is set.
  function automatic logic [31:0] model_load(input int size, input int o, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0 || size == 4) begin
      v = (rd >> (8 * o)) & 32'hFF;
      if (size == 0 && v >= 32'd128) v = v - 32'd256;
    end else if (size == 1 || size == 5) begin
      v = (rd >> (8 * (o & 2))) & 32'hFFFF;
      if (size == 1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drive every DUT input in one place.
  task automatic applyStimulus(input logic req, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rvalid, input logic [31:0] rdata);
    lsu_req_i     = req;
    lsu_we_i      = we;
    lsu_size_i    = size;
    lsu_addr_i    = addr;
    lsu_data_i    = wdata;
    data_rvalid_i = rvalid;
    data_rdata_i  = rdata;
  endtask

  // One comparison: counted, asserted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete core access. lat = WAIT cycles before rvalid; a lat of
  // MAX_WAIT or more lets the access time out. The core keeps lsu_req_i high
  // while stalled, as a real pipeline would.
  task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int lat);
    bit legal;
    bit glitch;
    int stalls;
    int o;
    o = int'(addr[1:0]);
    legal = model_legal(we, int'(size), o);
    @(posedge clk_i); #1;
    applyStimulus(1'b1, we, size, addr, wdata, 1'b0, $urandom);
    @(negedge clk_i);
    if (!legal) begin
      checkOutput({tag, ".req"}, 32'(data_req_o), 32'd0);
      checkOutput({tag, ".err"}, 32'(lsu_err_o), 32'd1);
      checkOutput({tag, ".stall"}, 32'(lsu_stall_req_o), 32'd0);
      @(posedge clk_i); #1;
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk_i);
      checkOutput({tag, ".err_clear"}, 32'(lsu_err_o), 32'd0);
      return;
    end
    checkOutput({tag, ".req"}, 32'(data_req_o), 32'd1);
    checkOutput({tag, ".we"}, 32'(data_we_o), 32'(we));
    checkOutput({tag, ".be"}, 32'(data_be_o), model_be(int'(size), o));
    checkOutput({tag, ".addr"}, data_addr_o, addr & ~32'd3);
    checkOutput({tag, ".err0"}, 32'(lsu_err_o), 32'd0);
    if (we) checkOutput({tag, ".wdata"}, data_wdata_o, model_wdata(int'(size), wdata));
    stalls = lsu_stall_req_o ? 1 : 0;
    glitch = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk_i); #1;
      applyStimulus(1'b1, we, size, addr, wdata, (i == lat), (i == lat) ? rdata : $urandom);
      @(negedge clk_i);
      if (data_req_o) glitch = 1'b1;
      if (i == lat) begin
        checkOutput({tag, ".data"}, lsu_data_o, we ? 32'h0 : model_load(int'(size), o, rdata));
        checkOutput({tag, ".done_stall"}, 32'(lsu_stall_req_o), 32'd0);
        checkOutput({tag, ".done_err"}, 32'(lsu_err_o), 32'd0);
        break;
      end
      if (i == MAX_WAIT - 1) begin
        checkOutput({tag, ".to_err"}, 32'(lsu_err_o), 32'd1);
        checkOutput({tag, ".to_stall"}, 32'(lsu_stall_req_o), 32'd0);
        checkOutput({tag, ".to_data"}, lsu_data_o, 32'h0);
        break;
      end
      if (lsu_err_o || lsu_data_o != 32'h0) glitch = 1'b1;
      if (lsu_stall_req_o) stalls++;
    end
    checkOutput({tag, ".wait_quiet"}, 32'(glitch), 32'd0);
    checkOutput({tag, ".stall_cycles"}, 32'(stalls), 32'((lat < MAX_WAIT) ? lat + 1 : MAX_WAIT));
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk_i);
    checkOutput({tag, ".idle"}, 32'({lsu_stall_req_o, lsu_err_o, data_req_o}), 32'd0);
  endtask

  // Directed scenarios first, then random traffic, then the summary.
  initial begin
    rst_n_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    #12;
    checkOutput("reset_outputs",
                32'(|{lsu_stall_req_o, lsu_data_o, lsu_err_o, data_req_o, data_we_o,
                      data_be_o, data_addr_o, data_wdata_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    $display("[TB] directed accesses");
    run_access("lb_0x103",  1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 2);
    run_access("lhu_0x202", 1'b0, 3'd5, 32'h0000_0202, 32'h0, 32'h8001_1234, 1);
    run_access("sb_0x11",   1'b1, 3'd0, 32'h0000_0011, 32'h1234_56AB, 32'h0, 0);
    run_access("sw_timeout", 1'b1, 3'd2, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, MAX_WAIT + 10);
    run_access("size3",     1'b0, 3'd3, 32'h0000_0020, 32'h0, 32'h0, 0);
    run_access("sbu_store", 1'b1, 3'd4, 32'h0000_0020, 32'h55, 32'h0, 0);
    run_access("sh_0x1",    1'b1, 3'd1, 32'h0000_0001, 32'hBEEF_1357, 32'h0, 1);
    run_access("lh_0x2",    1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h7FFF_0000, 0);
    run_access("lw_0x8",    1'b0, 3'd2, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 3);

    $display("[TB] reset during WAIT");
    @(posedge clk_i); #1;
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #2;
    checkOutput("midreset_outputs",
                32'(|{lsu_stall_req_o, lsu_data_o, lsu_err_o, data_req_o, data_we_o,
                      data_be_o, data_addr_o, data_wdata_o}), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h1122_3344);
    @(negedge clk_i);
    checkOutput("late_rvalid_data", lsu_data_o, 32'h0);
    checkOutput("late_rvalid_stall", 32'(lsu_stall_req_o), 32'd0);
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    run_access("lw_after_reset", 1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'hA5A5_5A5A, 1);

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      run_access($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
